// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster timing generator.
// Defaults describe the standard 640x480@60 mode.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam bit SYNC_ACT_LOW  = 1'b0;
    localparam bit SYNC_ACT_HIGH = 1'b1;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate strobe: divides the system clock by CLK_DIV while enabled.
// A tick is issued on the last clock of each pixel period.
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_check
        $error("CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync, coordinate and strobe outputs.
// Define VGA_PREFETCH_EN to make x_ptr/y_ptr/valid lead hs/vs/strobes by one pixel.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = SYNC_ACT_LOW,
    parameter bit VS_POL   = SYNC_ACT_LOW,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             hs,
    output logic             vs,
    output logic [CNT_W-1:0] x_ptr,
    output logic [CNT_W-1:0] y_ptr,
    output logic             valid,
    output logic             pix_en,
    output logic             line_start,
    output logic             frame_start
);
    localparam int     H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (longint'(H_TOTAL - 1) > CNT_MAX) begin : g_h_range
        $error("H_TOTAL-1 does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL - 1) > CNT_MAX) begin : g_v_range
        $error("V_TOTAL-1 does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_IDLE    = ~HS_POL;
    localparam logic             VS_IDLE    = ~VS_POL;

    // The reset position (last pixel of the frame) leads into (0,0), which is valid.
`ifdef VGA_PREFETCH_EN
    localparam logic VALID_RST = 1'b1;
`else
    localparam logic VALID_RST = 1'b0;
`endif

    logic             tick;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic [CNT_W-1:0] h_dsp, v_dsp;
    logic             hs_nxt, vs_nxt, valid_nxt;
    logic [CNT_W-1:0] x_nxt, y_nxt;

    pix_clk_en #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_clk_en (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    function automatic logic [CNT_W-1:0] h_step(input logic [CNT_W-1:0] h);
        return (h == H_LAST) ? '0 : h + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] v_step(input logic [CNT_W-1:0] v);
        return (v == V_LAST) ? '0 : v + CNT_W'(1);
    endfunction

    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        h_nxt = h_step(h_cnt);
        v_nxt = (h_cnt == H_LAST) ? v_step(v_cnt) : v_cnt;
`ifdef VGA_PREFETCH_EN
        h_dsp = h_step(h_nxt);
        v_dsp = (h_nxt == H_LAST) ? v_step(v_nxt) : v_nxt;
`else
        h_dsp = h_nxt;
        v_dsp = v_nxt;
`endif
        hs_nxt    = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? HS_POL : HS_IDLE;
        vs_nxt    = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? VS_POL : VS_IDLE;
        valid_nxt = (h_dsp <= H_ACT_LAST) && (v_dsp <= V_ACT_LAST);
        x_nxt     = (h_dsp <= H_ACT_LAST) ? h_dsp : '0;
        y_nxt     = (v_dsp <= V_ACT_LAST) ? v_dsp : '0;
    end

    // Outputs are decoded from the next position so they change together with the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hs          <= HS_IDLE;
            vs          <= VS_IDLE;
            valid       <= VALID_RST;
            x_ptr       <= '0;
            y_ptr       <= '0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= tick;
            line_start  <= tick && (h_nxt == '0);
            frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (tick) begin
                h_cnt <= h_nxt;
                v_cnt <= v_nxt;
                hs    <= hs_nxt;
                vs    <= vs_nxt;
                valid <= valid_nxt;
                x_ptr <= x_nxt;
                y_ptr <= y_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default-timing instance and a tiny-timing instance.
// A position model pushes every expected pixel into a queue; negedge monitors pop and compare.
module tb_vga_timing_gen;

`ifdef VGA_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, div;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int div, h, v;
    } pos_t;

    typedef struct packed {
        logic pe, hs, vs, valid, ls, fs;
        int   x, y;
    } rec_t;

    cfg_t cfg_d = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, div:2, hpol:1'b0, vpol:1'b0};
    cfg_t cfg_t_ = '{ha:4, hf:1, hsw:2, hb:1, va:3, vf:1, vsw:1, vb:1, div:1, hpol:1'b1, vpol:1'b0};

    logic clk = 1'b0;
    logic reset_d = 1'b1, en_d = 1'b0, reset_t = 1'b1, en_t = 1'b0;
    logic hs_d, vs_d, valid_d, pix_en_d, line_start_d, frame_start_d;
    logic hs_t, vs_t, valid_t, pix_en_t, line_start_t, frame_start_t;
    logic [9:0] x_d, y_d, x_t, y_t;

    int   n_checks = 0;
    int   n_errors = 0;
    pos_t s_d, s_t;
    rec_t q_d[$];
    rec_t q_t[$];

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset_d), .en(en_d), .hs(hs_d), .vs(vs_d), .x_ptr(x_d), .y_ptr(y_d),
        .valid(valid_d), .pix_en(pix_en_d), .line_start(line_start_d), .frame_start(frame_start_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .CNT_W(10)
    ) dut_t (
        .clk(clk), .reset(reset_t), .en(en_t), .hs(hs_t), .vs(vs_t), .x_ptr(x_t), .y_ptr(y_t),
        .valid(valid_t), .pix_en(pix_en_t), .line_start(line_start_t), .frame_start(frame_start_t)
    );

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic rec_t mk(logic pe, logic hs, logic vs, logic valid, logic ls, logic fs, int x, int y);
        rec_t r;
        r.pe = pe; r.hs = hs; r.vs = vs; r.valid = valid; r.ls = ls; r.fs = fs; r.x = x; r.y = y;
        return r;
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("pe=%b hs=%b vs=%b valid=%b ls=%b fs=%b x=%0d y=%0d",
                         r.pe, r.hs, r.vs, r.valid, r.ls, r.fs, r.x, r.y);
    endfunction

    function automatic rec_t cap_d();
        return mk(pix_en_d, hs_d, vs_d, valid_d, line_start_d, frame_start_d, int'(x_d), int'(y_d));
    endfunction

    function automatic rec_t cap_t();
        return mk(pix_en_t, hs_t, vs_t, valid_t, line_start_t, frame_start_t, int'(x_t), int'(y_t));
    endfunction

    function automatic pos_t adv(cfg_t c, pos_t p);
        pos_t n = p;
        n.h = p.h + 1;
        if (n.h == c.ha + c.hf + c.hsw + c.hb) begin
            n.h = 0;
            n.v = p.v + 1;
            if (n.v == c.va + c.vf + c.vsw + c.vb) n.v = 0;
        end
        return n;
    endfunction

    // Expected outputs for a raster position, straight from the sync/active window rules.
    function automatic rec_t expect_rec(cfg_t c, pos_t p);
        pos_t d = PF ? adv(c, p) : p;
        logic hs_on = (p.h >= c.ha + c.hf) && (p.h < c.ha + c.hf + c.hsw);
        logic vs_on = (p.v >= c.va + c.vf) && (p.v < c.va + c.vf + c.vsw);
        return mk(1'b1, hs_on ? c.hpol : !c.hpol, vs_on ? c.vpol : !c.vpol,
                  (d.h < c.ha) && (d.v < c.va), p.h == 0, (p.h == 0) && (p.v == 0),
                  (d.h < c.ha) ? d.h : 0, (d.v < c.va) ? d.v : 0);
    endfunction

    function automatic rec_t rst_rec(cfg_t c);
        return mk(1'b0, !c.hpol, !c.vpol, PF, 1'b0, 1'b0, 0, 0);
    endfunction

    function automatic rec_t first_rec(cfg_t c);
        return mk(1'b1, !c.hpol, !c.vpol, 1'b1, 1'b1, 1'b1, int'(PF), 0);
    endfunction

    task automatic model_edge(input cfg_t c, input logic rst, input logic e, input pos_t s,
                              output pos_t n, output logic tk);
        n  = s;
        tk = 1'b0;
        if (rst) begin
            n.div = 0;
            n.h   = c.ha + c.hf + c.hsw + c.hb - 1;
            n.v   = c.va + c.vf + c.vsw + c.vb - 1;
        end else if (e) begin
            if (s.div == c.div - 1) begin
                n     = adv(c, s);
                n.div = 0;
                tk    = 1'b1;
            end else begin
                n.div = s.div + 1;
            end
        end
    endtask

    task automatic step_d(input logic rst, input logic e);
        pos_t n;
        logic tk;
        reset_d = rst;
        en_d    = e;
        @(posedge clk);
        model_edge(cfg_d, rst, e, s_d, n, tk);
        s_d = n;
        if (tk) q_d.push_back(expect_rec(cfg_d, n));
        #1;
    endtask

    task automatic step_t(input logic rst, input logic e);
        pos_t n;
        logic tk;
        reset_t = rst;
        en_t    = e;
        @(posedge clk);
        model_edge(cfg_t_, rst, e, s_t, n, tk);
        s_t = n;
        if (tk) q_t.push_back(expect_rec(cfg_t_, n));
        #1;
    endtask

    always @(negedge clk) begin
        rec_t got, want;
        got = cap_d();
        if (got.pe === 1'b1) begin
            if (q_d.size() == 0) begin
                check("d_sb_extra", 1'b0, $sformatf("got unexpected pixel %s", fmt(got)));
            end else begin
                want = q_d.pop_front();
                check("d_sb_pixel", got === want, $sformatf("got %s want %s", fmt(got), fmt(want)));
            end
        end else if (q_d.size() != 0) begin
            want = q_d.pop_front();
            check("d_sb_missing", 1'b0, $sformatf("got pix_en=%b want %s", got.pe, fmt(want)));
        end
    end

    always @(negedge clk) begin
        rec_t got, want;
        got = cap_t();
        if (got.pe === 1'b1) begin
            if (q_t.size() == 0) begin
                check("t_sb_extra", 1'b0, $sformatf("got unexpected pixel %s", fmt(got)));
            end else begin
                want = q_t.pop_front();
                check("t_sb_pixel", got === want, $sformatf("got %s want %s", fmt(got), fmt(want)));
            end
        end else if (q_t.size() != 0) begin
            want = q_t.pop_front();
            check("t_sb_missing", 1'b0, $sformatf("got pix_en=%b want %s", got.pe, fmt(want)));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        int   k, hs_low, hs_first, v_cnt_ok, period, hit_clk, ymax;
        bit   ok;
        logic [7:0] hmask;
        logic [5:0] vmask;

        // ---------------- default timing instance ----------------
        step_d(1'b1, 1'b1);
        step_d(1'b1, 1'b1);
        r = cap_d();
        check("d_reset", r === rst_rec(cfg_d), $sformatf("got %s want %s", fmt(r), fmt(rst_rec(cfg_d))));

        step_d(1'b0, 1'b1);
        check("d_first_edge_quiet", pix_en_d === 1'b0, $sformatf("got pix_en=%b want 0", pix_en_d));
        step_d(1'b0, 1'b1);
        r = cap_d();
        check("d_first_pixel", r === first_rec(cfg_d), $sformatf("got %s want %s", fmt(r), fmt(first_rec(cfg_d))));

        k = 0; hs_low = 0; hs_first = -1; period = -1;
        v_cnt_ok = valid_d ? 1 : 0;
        for (int i = 1; i <= 2000; i++) begin
            step_d(1'b0, 1'b1);
            if (pix_en_d) begin
                k++;
                if (line_start_d) begin
                    period = i;
                    break;
                end
                if (!hs_d) begin
                    if (hs_first < 0) hs_first = k;
                    hs_low++;
                end
                if (valid_d) v_cnt_ok++;
            end
        end
        check("d_line_period", period == 1600, $sformatf("got %0d clks want 1600", period));
        check("d_hs_start", hs_first == 656, $sformatf("got %0d want 656", hs_first));
        check("d_hs_width", hs_low == 96, $sformatf("got %0d ticks want 96", hs_low));
        check("d_valid_per_line", v_cnt_ok == 640, $sformatf("got %0d ticks want 640", v_cnt_ok));

        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step_d(1'b0, 1'b1);
            if (pix_en_d && x_d == 10'd100) begin
                ok = 1'b1;
                break;
            end
        end
        check("d_seek_x100", ok && y_d == 10'd1, $sformatf("got found=%b y=%0d want found=1 y=1", ok, y_d));

        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_d(1'b0, 1'b0);
            r = cap_d();
            if (r !== mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 100, 1)) ok = 1'b0;
        end
        check("d_freeze", ok, $sformatf("got %s want frozen at x=100 y=1 strobes 0", fmt(r)));

        hit_clk = -1;
        for (int i = 1; i <= 8; i++) begin
            step_d(1'b0, 1'b1);
            if (pix_en_d) begin
                hit_clk = i;
                break;
            end
        end
        check("d_resume_x101", hit_clk == 2 && x_d == 10'd101,
              $sformatf("got clk=%0d x=%0d want clk=2 x=101", hit_clk, x_d));

        step_d(1'b0, 1'b1);
        step_d(1'b1, 1'b0);
        r = cap_d();
        check("d_reset_mid_en0", r === rst_rec(cfg_d), $sformatf("got %s want %s", fmt(r), fmt(rst_rec(cfg_d))));
        step_d(1'b0, 1'b1);
        check("d_restart_quiet", pix_en_d === 1'b0, $sformatf("got pix_en=%b want 0", pix_en_d));
        step_d(1'b0, 1'b1);
        r = cap_d();
        check("d_restart_pixel", r === first_rec(cfg_d), $sformatf("got %s want %s", fmt(r), fmt(first_rec(cfg_d))));
        step_d(1'b1, 1'b0);

        // ---------------- tiny timing instance ----------------
        step_t(1'b1, 1'b1);
        step_t(1'b1, 1'b1);
        r = cap_t();
        check("t_reset", r === rst_rec(cfg_t_), $sformatf("got %s want %s", fmt(r), fmt(rst_rec(cfg_t_))));
        step_t(1'b0, 1'b1);
        r = cap_t();
        check("t_first_pixel", r === first_rec(cfg_t_), $sformatf("got %s want %s", fmt(r), fmt(first_rec(cfg_t_))));

        hmask = '0; vmask = '0; ymax = 0; period = -1; ok = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            step_t(1'b0, 1'b1);
            if (frame_start_t) begin
                period = i;
                ok = (x_t == 10'(PF)) && (y_t == 10'd0) && line_start_t;
                break;
            end
            if (hs_t) hmask[i % 8] = 1'b1;
            if (!vs_t) vmask[i / 8] = 1'b1;
            if (int'(y_t) > ymax) ymax = int'(y_t);
        end
        check("t_frame_period", period == 48, $sformatf("got %0d clks want 48", period));
        check("t_hs_window", hmask == 8'b0110_0000, $sformatf("got %b want 01100000", hmask));
        check("t_vs_window", vmask == 6'b01_0000, $sformatf("got %b want 010000", vmask));
        check("t_y_max", ymax == 2, $sformatf("got %0d want 2", ymax));
        check("t_wrap_origin", ok, $sformatf("got x=%0d y=%0d ls=%b want x=%0d y=0 ls=1", x_t, y_t, line_start_t, PF));

        for (int i = 0; i < 10; i++) step_t(1'b0, 1'b1);
        check("t_pos_2_1", x_t == 10'(2 + PF) && y_t == 10'd1,
              $sformatf("got x=%0d y=%0d want x=%0d y=1", x_t, y_t, 2 + PF));
        step_t(1'b1, 1'b0);
        r = cap_t();
        check("t_reset_mid_en0", r === rst_rec(cfg_t_), $sformatf("got %s want %s", fmt(r), fmt(rst_rec(cfg_t_))));
        step_t(1'b0, 1'b1);
        r = cap_t();
        check("t_restart_pixel", r === first_rec(cfg_t_), $sformatf("got %s want %s", fmt(r), fmt(first_rec(cfg_t_))));
        step_t(1'b1, 1'b0);

        @(negedge clk);
        #1;
        check("sb_drain", q_d.size() == 0 && q_t.size() == 0,
              $sformatf("got %0d/%0d queued want 0/0", q_d.size(), q_t.size()));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
